id_regfile_scoreboard: RTL and testbench
========================================

Name: id_regfile_scoreboard

Overview:
- ID-side consumer of wb_to_id_bus: the 32x32 general register file, written by the WB stage and read by decode.
- Adds a per-register in-flight-write scoreboard so ID can stall on RAW hazards until WB retires the producing write.
- Sits inside the ID stage. It is the receiving end of the {rf_we, rf_waddr, rf_wdata} bus driven by WB.

Parameters:
- NREG, 32: number of architectural registers; r0 is hardwired to zero.
- DW, 32: data width.
- CNT_W, 2: scoreboard counter width per register; supports at most 3 in-flight writes (EX/MEM/WB).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- wb_to_id_bus  in  `WB_TO_ID_BUS_WIDTH (38)  {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
- rf_raddr1  in  5  read port 1 address
- rf_raddr2  in  5  read port 2 address
- rd1_used  in  1  ID actually consumes port 1 this cycle
- rd2_used  in  1  ID actually consumes port 2 this cycle
- rf_rdata1  out  32  read data 1, combinational
- rf_rdata2  out  32  read data 2, combinational
- issue_valid  in  1  ID hands an instruction to EX this cycle (ID already gates this with !id_stall)
- issue_gr_we  in  1  issued instruction writes a GPR
- issue_dest  in  5  destination register of the issued instruction
- flush  in  1  discard all in-flight instructions in EX/MEM/WB
- id_stall  out  1  RAW hazard; ID must hold
- sb_overflow  out  1  sticky error flag
- sb_underflow  out  1  sticky error flag

Behaviour:
- Reset: all scoreboard counters = 0, sb_overflow = 0, sb_underflow = 0, so id_stall = 0. Register storage is not reset; only r0 reads as 0.
- Write:
  - On posedge clk, when rf_we=1 and rf_waddr!=0, storage[rf_waddr] <= rf_wdata.
  - Writes to r0 are discarded.
- Read:
  - raddr==0 returns 0.
  - If rf_we=1, rf_waddr==raddr and raddr!=0, return rf_wdata (write-through bypass, same cycle).
  - Otherwise return storage[raddr].
  - Both ports are independent and may use the same address.
- Scoreboard, per register r (r0 has no counter and never hazards):
  - inc = issue_valid & issue_gr_we & (issue_dest==r)
  - dec = rf_we & (rf_waddr==r)
  - inc and dec together: count unchanged.
  - inc only: count+1; if count==3, hold at 3 and set sb_overflow.
  - dec only: count-1; if count==0, hold at 0 and set sb_underflow.
- Flush:
  - All counters <= 0 next cycle, overriding inc/dec in the same cycle. The WB write in that cycle is still performed to storage.
  - After a flush, a WB retire seen on a zero counter is legal and does not set sb_underflow. This window lasts 3 cycles after flush; a 2-bit down-counter tracks it.
- Stall (hz_i = hazard on port i, i = 1, 2):
  - hz_i = rd_i_used & raddr_i!=0 & cnt[raddr_i]!=0 & !(cnt[raddr_i]==1 & dec on raddr_i)
  - id_stall = hz1 | hz2, purely combinational from the current counters and inputs.
- Sticky flags: set on the cycle after the error and cleared only by resetn.
- Latency:
  - Read is 0 cycles.
  - A counter change is visible the cycle after issue or retire.
  - id_stall falls in the same cycle WB writes the last pending value.
- resetn is asserted asynchronously mid-operation: counters and flags clear immediately. Storage keeps its contents.

Decomposition:
- Shared header mycpu_top.h holds `WB_TO_ID_BUS_WIDTH, the GPR address width (5) and the r0 index constant.
- One natural sub-module: sb_counter, a single saturating up/down counter with inc, dec, clr and ovf/unf pulses, instantiated 31 times.
- Storage, read mux and bypass stay in the top module.

Test Plan:
- Write then read: WB writes r5=0x1234_5678; the next cycle raddr1=5 -> rf_rdata1=0x1234_5678. The same cycle as the write, raddr2=5 -> 0x1234_5678 via bypass. A write to r0 -> raddr=0 still reads 0.
- Single RAW: issue dest=r3; next cycle raddr1=3, rd1_used=1 -> id_stall=1 until the cycle WB asserts rf_we with waddr=3, when id_stall=0 and rf_rdata1 = the WB data. With rd1_used=0 -> id_stall=0 throughout.
- Back-to-back writers: issue r7 three times -> cnt[7]=3. The stall stays high through the first two retires and drops on the third retire cycle. A 4th issue while cnt=3 -> sb_overflow=1 the next cycle.
- Simultaneous issue and retire on r9 with cnt=1 -> cnt stays 1. Stall is computed correctly with the bypass.
- Flush: cnt[4]=2 and cnt[6]=1, assert flush -> all counters 0 next cycle and id_stall=0. A stale WB retire on r4 2 cycles later -> no sb_underflow. A retire on r4 with cnt=0 10 cycles later -> sb_underflow=1.
- Async reset: drop resetn mid-stream with counters nonzero -> id_stall, sb_overflow and sb_underflow are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_regfile_scoreboard_pkg.sv
// Shared constants for the ID-stage register file and its RAW scoreboard.
// Holds the GPR address width, r0 index, default sizes and WB->ID bus width.
package id_regfile_scoreboard_pkg;

    localparam int GPR_AW = 5;
    localparam logic [GPR_AW-1:0] R0_IDX = '0;

    localparam int NREG_DEF  = 32;
    localparam int DW_DEF    = 32;
    localparam int CNT_W_DEF = 2;

    // {rf_we, rf_waddr, rf_wdata}
    localparam int WB_TO_ID_BUS_WIDTH = 1 + GPR_AW + DW_DEF;

    // Cycles after a flush in which a retire on an empty counter is legal
    localparam logic [1:0] FLUSH_WIN = 2'd3;

endpackage

// File: rtl/id_regfile_scoreboard_sb_counter.sv
// Saturating up/down in-flight-write counter for one register.
// Ports: clk, resetn, inc_i, dec_i, clr_i -> cnt_o, ovf_o/unf_o (pulses).
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clr wins over inc/dec and suppresses error pulses
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == MAX) ovf_o = 1'b1;
            else              cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) unf_o = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/id_regfile_scoreboard.sv
// ID-stage GPR file (WB write, 2 bypassed reads) with per-register RAW
// scoreboard. Ports: wb_to_id_bus in; raddr/used -> rdata, id_stall, flags.
module id_regfile_scoreboard
    import id_regfile_scoreboard_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DW+GPR_AW:0] wb_to_id_bus,
    input  logic [GPR_AW-1:0] rf_raddr1,
    input  logic [GPR_AW-1:0] rf_raddr2,
    input  logic              rd1_used,
    input  logic              rd2_used,
    output logic [DW-1:0]     rf_rdata1,
    output logic [DW-1:0]     rf_rdata2,
    input  logic              issue_valid,
    input  logic              issue_gr_we,
    input  logic [GPR_AW-1:0] issue_dest,
    input  logic              flush,
    output logic              id_stall,
    output logic              sb_overflow,
    output logic              sb_underflow
);

    logic              rf_we;
    logic [GPR_AW-1:0] rf_waddr;
    logic [DW-1:0]     rf_wdata;

    assign {rf_we, rf_waddr, rf_wdata} = wb_to_id_bus;

    // Storage is intentionally not reset
    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (rf_we && rf_waddr != R0_IDX) mem_q[rf_waddr] <= rf_wdata;
    end

    always_comb begin
        if (rf_raddr1 == R0_IDX)
            rf_rdata1 = '0;
        else if (rf_we && rf_waddr == rf_raddr1)
            rf_rdata1 = rf_wdata;
        else
            rf_rdata1 = mem_q[rf_raddr1];
    end

    always_comb begin
        if (rf_raddr2 == R0_IDX)
            rf_rdata2 = '0;
        else if (rf_we && rf_waddr == rf_raddr2)
            rf_rdata2 = rf_wdata;
        else
            rf_rdata2 = mem_q[rf_raddr2];
    end

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  ovf_v;
    logic [NREG-1:0]  unf_v;

    assign cnt[0]   = '0;
    assign ovf_v[0] = 1'b0;
    assign unf_v[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        logic inc;
        logic dec;
        assign inc = issue_valid & issue_gr_we
                   & (issue_dest == GPR_AW'(r));
        assign dec = rf_we & (rf_waddr == GPR_AW'(r));
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .resetn (resetn),
            .inc_i  (inc),
            .dec_i  (dec),
            .clr_i  (flush),
            .cnt_o  (cnt[r]),
            .ovf_o  (ovf_v[r]),
            .unf_o  (unf_v[r])
        );
    end

    // A lone pending write retiring this cycle is covered by the bypass
    logic hz1;
    logic hz2;

    always_comb begin
        hz1 = rd1_used && rf_raddr1 != R0_IDX
            && cnt[rf_raddr1] != '0
            && !(cnt[rf_raddr1] == CNT_W'(1)
                 && rf_we && rf_waddr == rf_raddr1);
        hz2 = rd2_used && rf_raddr2 != R0_IDX
            && cnt[rf_raddr2] != '0
            && !(cnt[rf_raddr2] == CNT_W'(1)
                 && rf_we && rf_waddr == rf_raddr2);
    end

    assign id_stall = hz1 | hz2;

    // win_q counts down the post-flush window where stale retires are legal
    logic [1:0] win_q;
    logic       ovf_q;
    logic       unf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (flush)             win_q <= FLUSH_WIN;
            else if (win_q != '0)  win_q <= win_q - 1'b1;
            if (|ovf_v)                  ovf_q <= 1'b1;
            if (|unf_v && win_q == '0)   unf_q <= 1'b1;
        end
    end

    assign sb_overflow  = ovf_q;
    assign sb_underflow = unf_q;

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Self-checking bench for id_regfile_scoreboard: directed scenarios plus a
// randomized phase, checked every cycle against a behavioural model.
module tb_id_regfile_scoreboard;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [37:0] bus;
    assign bus = {we, wa, wd};

    logic [4:0]  ra1, ra2, idst;
    logic        u1, u2, iv, igw, flush;
    logic [31:0] rd1, rd2;
    logic        stall, ovf, unf;

    id_regfile_scoreboard dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_to_id_bus (bus),
        .rf_raddr1    (ra1),
        .rf_raddr2    (ra2),
        .rd1_used     (u1),
        .rd2_used     (u2),
        .rf_rdata1    (rd1),
        .rf_rdata2    (rd2),
        .issue_valid  (iv),
        .issue_gr_we  (igw),
        .issue_dest   (idst),
        .flush        (flush),
        .id_stall     (stall),
        .sb_overflow  (ovf),
        .sb_underflow (unf)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: pending-write counts, known storage, sticky flags
    int          cnt_m [32];
    logic [31:0] mem_m [32];
    bit          mv    [32];
    bit          ovf_m, unf_m;
    int          cyc = 0;
    int          flush_at = -100;
    int          cand [$];

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic bit hz_m(logic used, logic [4:0] a);
        int pend;
        if (!used || a == 0) return 1'b0;
        pend = cnt_m[a] - ((we && wa == a) ? 1 : 0);
        return pend > 0;
    endfunction

    function automatic bit exp_rd(logic [4:0] a, output logic [31:0] v);
        v = '0;
        if (a == 0) return 1'b1;
        if (we && wa == a) begin v = wd; return 1'b1; end
        if (mv[a]) begin v = mem_m[a]; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic void compare();
        logic [31:0] v;
        if (exp_rd(ra1, v)) chk("rdata1", rd1, v);
        if (exp_rd(ra2, v)) chk("rdata2", rd2, v);
        chk("id_stall", 32'(stall),
            32'(hz_m(u1, ra1) | hz_m(u2, ra2)));
        chk("sb_overflow", 32'(ovf), 32'(ovf_m));
        chk("sb_underflow", 32'(unf), 32'(unf_m));
    endfunction

    function automatic void update();
        bit o = 1'b0;
        bit u = 1'b0;
        cyc++;
        for (int r = 1; r < 32; r++) begin
            bit inc = iv && igw && idst == r;
            bit dec = we && wa == r;
            if (flush) cnt_m[r] = 0;
            else if (inc && !dec) begin
                if (cnt_m[r] == 3) o = 1'b1;
                else cnt_m[r]++;
            end else if (dec && !inc) begin
                if (cnt_m[r] == 0) begin
                    if (cyc - flush_at > 3) u = 1'b1;
                end else cnt_m[r]--;
            end
        end
        if (flush) flush_at = cyc;
        if (we && wa != 0) begin mem_m[wa] = wd; mv[wa] = 1'b1; end
        ovf_m |= o;
        unf_m |= u;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        flush_at = -100;
    endfunction

    task automatic half();
        @(negedge clk);
        compare();
    endtask

    task automatic fin();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic idle();
        we = 0; wa = 0; wd = 0;
        ra1 = 0; ra2 = 0; u1 = 0; u2 = 0;
        iv = 0; igw = 0; idst = 0; flush = 0;
    endtask

    task automatic issue(input int d);
        iv = 1; igw = 1; idst = 5'(d);
    endtask

    task automatic retire(input int a, input logic [31:0] d);
        we = 1; wa = 5'(a); wd = d;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mv[r] = 1'b0;
        model_reset();
        idle();
        resetn = 0;
        #12;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_unf", 32'(unf), 32'd0);
        @(posedge clk); #1;
        resetn = 1;

        // write then read, with bypass and r0
        idle(); issue(5); step();
        idle(); retire(5, 32'h1234_5678); ra2 = 5; u2 = 1;
        half();
        chk("bypass_r5", rd2, 32'h1234_5678);
        chk("retire_nostall", 32'(stall), 32'd0);
        fin();
        idle(); ra1 = 5; u1 = 1;
        half(); chk("read_r5", rd1, 32'h1234_5678); fin();
        idle(); retire(0, 32'hDEAD_BEEF); u1 = 1; u2 = 1;
        half();
        chk("r0_wr_rd1", rd1, 32'd0);
        chk("r0_wr_rd2", rd2, 32'd0);
        fin();

        // single RAW on r3
        idle(); issue(3); step();
        for (int i = 0; i < 3; i++) begin
            idle(); ra1 = 3; u1 = 1;
            half(); chk("raw_hold", 32'(stall), 32'd1); fin();
        end
        idle(); ra1 = 3; u1 = 1; retire(3, 32'hA5A5_0003);
        half();
        chk("raw_release", 32'(stall), 32'd0);
        chk("raw_data", rd1, 32'hA5A5_0003);
        fin();
        idle(); issue(3); step();
        idle(); ra1 = 3; u1 = 0;
        half(); chk("raw_unused", 32'(stall), 32'd0); fin();
        idle(); retire(3, 32'h0000_3333); step();

        // simultaneous issue/retire on r9
        idle(); issue(9); step();
        idle(); issue(9); retire(9, 32'h9999_0001); ra1 = 9; u1 = 1;
        half(); chk("r9_same", 32'(stall), 32'd0); fin();
        idle(); ra1 = 9; u1 = 1;
        half(); chk("r9_still1", 32'(stall), 32'd1); fin();
        idle(); retire(9, 32'h9999_0002); step();

        // flush with stale retire inside the window
        idle(); issue(4); step();
        idle(); issue(4); step();
        idle(); issue(6); step();
        idle(); flush = 1; ra1 = 4; u1 = 1; ra2 = 6; u2 = 1;
        half(); chk("pre_flush", 32'(stall), 32'd1); fin();
        idle(); ra1 = 4; u1 = 1; ra2 = 6; u2 = 1;
        half(); chk("post_flush", 32'(stall), 32'd0); fin();
        idle(); retire(4, 32'h4444_0001); step();
        idle();
        half(); chk("stale_ok", 32'(unf), 32'd0); fin();

        // randomized legal traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            ra1 = 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            u1 = 1'($urandom_range(0, 1));
            u2 = 1'($urandom_range(0, 1));
            iv = 1'($urandom_range(0, 1));
            igw = ($urandom_range(0, 4) != 0);
            idst = 5'($urandom_range(0, 7));
            if (idst != 0 && cnt_m[idst] >= 3) iv = 0;
            if ($urandom_range(0, 1) == 1) begin
                cand.delete();
                for (int r = 1; r < 8; r++)
                    if (cnt_m[r] > 0) cand.push_back(r);
                if (cand.size() > 0)
                    retire(cand[$urandom_range(0, cand.size() - 1)],
                           $urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                retire(0, $urandom);
            end
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        idle(); flush = 1; step();
        for (int i = 0; i < 5; i++) begin idle(); step(); end

        // back-to-back writers on r7, then overflow
        for (int i = 0; i < 3; i++) begin idle(); issue(7); step(); end
        for (int i = 0; i < 3; i++) begin
            idle(); ra1 = 7; u1 = 1;
            retire(7, 32'h7000_0000 + 32'(i));
            half();
            chk("b2b_stall", 32'(stall), (i < 2) ? 32'd1 : 32'd0);
            fin();
        end
        for (int i = 0; i < 4; i++) begin idle(); issue(7); step(); end
        idle();
        half(); chk("overflow", 32'(ovf), 32'd1); fin();
        idle(); flush = 1; step();
        for (int i = 0; i < 10; i++) begin idle(); step(); end

        // late retire on empty counter
        idle(); retire(4, 32'h4444_0002); step();
        idle();
        half(); chk("underflow", 32'(unf), 32'd1); fin();

        // async reset mid-stream
        idle(); issue(10); step();
        idle(); ra1 = 10; u1 = 1;
        #2;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        resetn = 0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_unf", 32'(unf), 32'd0);
        model_reset();
        @(posedge clk); #1;
        resetn = 1;
        for (int r = 1; r < 8; r++) begin
            idle(); ra1 = 5'(r); ra2 = 5'(r + 8); u1 = 1; u2 = 1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
